// File: rtl/i2c_regbank_pkg.sv
// I2C register bank shared types and defaults.
// Pointer wrap vs. saturate is selected by I2C_REGBANK_PTR_WRAP_EN.
package i2c_regbank_pkg;

  localparam int DEF_ADDR_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GETPTR = 3'd1,
    ST_WRDATA = 3'd2,
    ST_RDDATA = 3'd3,
    ST_NACKED = 3'd4
  } state_e;

endpackage

// File: rtl/i2c_regbank_mem.sv
// Register array with two write ports (A wins on same index)
// and two combinational read ports.
module i2c_regbank_mem
  import i2c_regbank_pkg::*;
#(
  parameter int AW = DEF_ADDR_W
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_a_we,
  input  logic [AW-1:0] i_a_addr,
  input  logic [7:0]    i_a_wdata,
  input  logic          i_b_we,
  input  logic [AW-1:0] i_b_addr,
  input  logic [7:0]    i_b_wdata,
  input  logic [AW-1:0] i_ra_addr,
  output logic [7:0]    o_ra_data,
  input  logic [AW-1:0] i_rb_addr,
  output logic [7:0]    o_rb_data
);

  localparam int NREGS = 2 ** AW;

  logic [7:0] r_mem [NREGS];
  logic       w_b_ok;

  assign w_b_ok = i_b_we && !(i_a_we && (i_a_addr == i_b_addr));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_mem[i] <= 8'h00;
      end
    end else begin
      if (w_b_ok) begin
        r_mem[i_b_addr] <= i_b_wdata;
      end
      if (i_a_we) begin
        r_mem[i_a_addr] <= i_a_wdata;
      end
    end
  end

  assign o_ra_data = r_mem[i_ra_addr];
  assign o_rb_data = r_mem[i_rb_addr];

endmodule

// File: rtl/i2c_regbank_ctrl.sv
// I2C slave register bank controller; define I2C_REGBANK_PTR_WRAP_EN
// to wrap the pointer at the top instead of saturating.
module i2c_regbank_ctrl
  import i2c_regbank_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk6x,
  input  logic              reset,
  input  logic              devsel_i,
  input  logic              rw_bit_i,
  input  logic [7:0]        rxbyte_i,
  input  logic              rxbyte_v_i,
  output logic [7:0]        txbyte_o,
  input  logic              txbyte_deq_i,
  input  logic              tx_nacked_i,
  input  logic [ADDR_W-1:0] host_addr_i,
  input  logic [7:0]        host_wdata_i,
  input  logic              host_we_i,
  output logic [7:0]        host_rdata_o,
  output logic              wr_strobe_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [7:0]        wr_data_o
);

  localparam logic [ADDR_W-1:0] LAST = '1;

  state_e            r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic              r_armed;
  logic              r_wr_strobe;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [7:0]        r_wr_data;
  logic              w_wr;
  logic [ADDR_W-1:0] w_ptr_inc;

  assign w_wr = devsel_i && rxbyte_v_i && (r_state == ST_WRDATA);

`ifdef I2C_REGBANK_PTR_WRAP_EN
  assign w_ptr_inc = r_ptr + ADDR_W'(1);
`else
  assign w_ptr_inc = (r_ptr == LAST) ? r_ptr : r_ptr + ADDR_W'(1);
`endif

  // r_armed blocks a transfer until devsel has been seen low after reset
  always_ff @(posedge clk6x or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_armed <= 1'b0;
    end else if (!devsel_i) begin
      r_state <= ST_IDLE;
      r_armed <= 1'b1;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (r_armed) begin
            r_state <= rw_bit_i ? ST_RDDATA : ST_GETPTR;
          end
        end
        ST_GETPTR: begin
          if (rxbyte_v_i) begin
            r_ptr   <= rxbyte_i[ADDR_W-1:0];
            r_state <= ST_WRDATA;
          end
        end
        ST_WRDATA: begin
          if (rxbyte_v_i) begin
            r_ptr <= w_ptr_inc;
          end
        end
        ST_RDDATA: begin
          if (tx_nacked_i) begin
            r_state <= ST_NACKED;
          end else if (txbyte_deq_i) begin
            r_ptr <= w_ptr_inc;
          end
        end
        ST_NACKED: begin
          r_state <= ST_NACKED;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk6x or posedge reset) begin
    if (reset) begin
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= 8'h00;
    end else begin
      r_wr_strobe <= w_wr;
      if (w_wr) begin
        r_wr_addr <= r_ptr;
        r_wr_data <= rxbyte_i;
      end
    end
  end

  assign wr_strobe_o = r_wr_strobe;
  assign wr_addr_o   = r_wr_addr;
  assign wr_data_o   = r_wr_data;

  i2c_regbank_mem #(
    .AW (ADDR_W)
  ) u_mem (
    .i_clk     (clk6x),
    .i_rst     (reset),
    .i_a_we    (w_wr),
    .i_a_addr  (r_ptr),
    .i_a_wdata (rxbyte_i),
    .i_b_we    (host_we_i),
    .i_b_addr  (host_addr_i),
    .i_b_wdata (host_wdata_i),
    .i_ra_addr (r_ptr),
    .o_ra_data (txbyte_o),
    .i_rb_addr (host_addr_i),
    .o_rb_data (host_rdata_o)
  );

endmodule

// File: tb/tb_i2c_regbank_ctrl.sv
// Scoreboard bench for i2c_regbank_ctrl: directed I2C/host traffic,
// expected reads and write strobes queued and checked by a monitor.
module tb_i2c_regbank_ctrl;

  logic       clk6x;
  logic       reset;
  logic       devsel_i;
  logic       rw_bit_i;
  logic [7:0] rxbyte_i;
  logic       rxbyte_v_i;
  logic [7:0] txbyte_o;
  logic       txbyte_deq_i;
  logic       tx_nacked_i;
  logic [3:0] host_addr_i;
  logic [7:0] host_wdata_i;
  logic       host_we_i;
  logic [7:0] host_rdata_o;
  logic       wr_strobe_o;
  logic [3:0] wr_addr_o;
  logic [7:0] wr_data_o;

  i2c_regbank_ctrl #(.ADDR_W(4)) dut (
    .clk6x        (clk6x),
    .reset        (reset),
    .devsel_i     (devsel_i),
    .rw_bit_i     (rw_bit_i),
    .rxbyte_i     (rxbyte_i),
    .rxbyte_v_i   (rxbyte_v_i),
    .txbyte_o     (txbyte_o),
    .txbyte_deq_i (txbyte_deq_i),
    .tx_nacked_i  (tx_nacked_i),
    .host_addr_i  (host_addr_i),
    .host_wdata_i (host_wdata_i),
    .host_we_i    (host_we_i),
    .host_rdata_o (host_rdata_o),
    .wr_strobe_o  (wr_strobe_o),
    .wr_addr_o    (wr_addr_o),
    .wr_data_o    (wr_data_o)
  );

  typedef struct {
    bit         host;
    logic [7:0] val;
    string      name;
  } exp_t;

  typedef struct {
    logic [3:0] a;
    logic [7:0] d;
  } wexp_t;

  exp_t  exp_q[$];
  wexp_t wr_q[$];
  exp_t  e;
  wexp_t w;
  logic  [7:0] act;
  logic  chk_req;
  int    checks;
  int    errors;

  initial begin
    clk6x = 1'b0;
    forever #5 clk6x = ~clk6x;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  always @(negedge clk6x) begin
    if (chk_req) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty got none want entry");
      end else begin
        e   = exp_q.pop_front();
        act = e.host ? host_rdata_o : txbyte_o;
        if (act !== e.val) begin
          errors++;
          $display("FAIL %s got %h want %h", e.name, act, e.val);
        end
      end
    end
    if (wr_strobe_o !== 1'b0) begin
      checks++;
      if (wr_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe got addr %h data %h want none",
                 wr_addr_o, wr_data_o);
      end else begin
        w = wr_q.pop_front();
        if (wr_addr_o !== w.a || wr_data_o !== w.d) begin
          errors++;
          $display("FAIL wr_strobe got %h/%h want %h/%h",
                   wr_addr_o, wr_data_o, w.a, w.d);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk6x);
    #1;
  endtask

  task automatic chk(input bit host, input logic [3:0] a,
                     input logic [7:0] v, input string n);
    if (host) host_addr_i = a;
    exp_q.push_back('{host, v, n});
    chk_req = 1'b1;
    @(negedge clk6x);
    #1;
    chk_req = 1'b0;
  endtask

  task automatic start(input logic rw);
    devsel_i = 1'b1;
    rw_bit_i = rw;
    tick();
  endtask

  task automatic stop();
    devsel_i = 1'b0;
    tick();
    tick();
  endtask

  task automatic rx(input logic [7:0] b);
    rxbyte_i   = b;
    rxbyte_v_i = 1'b1;
    tick();
    rxbyte_v_i = 1'b0;
  endtask

  task automatic exp_wr(input logic [3:0] a, input logic [7:0] d);
    wr_q.push_back('{a, d});
  endtask

  task automatic hwr(input logic [3:0] a, input logic [7:0] d);
    host_addr_i  = a;
    host_wdata_i = d;
    host_we_i    = 1'b1;
    tick();
    host_we_i    = 1'b0;
  endtask

  task automatic rx_host(input logic [7:0] b, input logic [3:0] a,
                         input logic [7:0] d);
    host_addr_i  = a;
    host_wdata_i = d;
    host_we_i    = 1'b1;
    rx(b);
    host_we_i    = 1'b0;
  endtask

  task automatic deq();
    txbyte_deq_i = 1'b1;
    tick();
    txbyte_deq_i = 1'b0;
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    chk_req      = 1'b0;
    reset        = 1'b1;
    devsel_i     = 1'b0;
    rw_bit_i     = 1'b0;
    rxbyte_i     = 8'h00;
    rxbyte_v_i   = 1'b0;
    txbyte_deq_i = 1'b0;
    tx_nacked_i  = 1'b0;
    host_addr_i  = 4'd0;
    host_wdata_i = 8'h00;
    host_we_i    = 1'b0;
    tick();
    tick();
    chk(1'b0, 4'd0, 8'h00, "reset_tx");
    chk(1'b1, 4'd9, 8'h00, "reset_host");
    reset = 1'b0;
    tick();

    // pointer load then two data writes
    start(1'b0);
    rx(8'h03);
    exp_wr(4'd3, 8'hA5);
    rx(8'hA5);
    exp_wr(4'd4, 8'h5A);
    rx(8'h5A);
    stop();
    chk(1'b1, 4'd3, 8'hA5, "wr_reg3");
    chk(1'b1, 4'd4, 8'h5A, "wr_reg4");

    // sequential read, NACK hold, continue after devsel drop
    hwr(4'd6, 8'h66);
    start(1'b0);
    rx(8'h03);
    stop();
    start(1'b1);
    chk(1'b0, 4'd0, 8'hA5, "rd_ptr3");
    deq();
    chk(1'b0, 4'd0, 8'h5A, "rd_ptr4");
    deq();
    chk(1'b0, 4'd0, 8'h00, "rd_ptr5");
    tx_nacked_i = 1'b1;
    tick();
    tx_nacked_i = 1'b0;
    deq();
    chk(1'b0, 4'd0, 8'h00, "nacked_hold");
    stop();
    start(1'b1);
    chk(1'b0, 4'd0, 8'h00, "rd_resume5");
    deq();
    chk(1'b0, 4'd0, 8'h66, "rd_resume6");
    stop();

    // top-of-bank pointer behaviour
    start(1'b0);
    rx(8'h0F);
    exp_wr(4'd15, 8'h11);
    rx(8'h11);
`ifdef I2C_REGBANK_PTR_WRAP_EN
    exp_wr(4'd0, 8'h22);
`else
    exp_wr(4'd15, 8'h22);
`endif
    rx(8'h22);
    stop();
`ifdef I2C_REGBANK_PTR_WRAP_EN
    chk(1'b1, 4'd15, 8'h11, "top_reg15");
    chk(1'b1, 4'd0,  8'h22, "top_reg0");
`else
    chk(1'b1, 4'd15, 8'h22, "top_reg15");
    chk(1'b1, 4'd0,  8'h00, "top_reg0");
`endif

    // host vs I2C write collisions
    start(1'b0);
    rx(8'h04);
    exp_wr(4'd4, 8'h77);
    rx_host(8'h77, 4'd4, 8'hFF);
    stop();
    chk(1'b1, 4'd4, 8'h77, "coll_same4");
    start(1'b0);
    rx(8'h04);
    exp_wr(4'd4, 8'h77);
    rx_host(8'h77, 4'd7, 8'hFF);
    stop();
    chk(1'b1, 4'd7, 8'hFF, "coll_diff7");
    chk(1'b1, 4'd4, 8'h77, "coll_diff4");

    // rx pulses during a read are ignored
    hwr(4'd5, 8'h55);
    start(1'b1);
    rx(8'h99);
    rx(8'h98);
    chk(1'b0, 4'd0, 8'h55, "rd_rx_ign_tx");
    chk(1'b1, 4'd5, 8'h55, "rd_rx_ign_reg5");
    chk(1'b1, 4'd4, 8'h77, "rd_rx_ign_reg4");
    stop();

    // reset mid-transfer, devsel held high across release
    start(1'b0);
    rx(8'h02);
    reset = 1'b1;
    tick();
    chk(1'b0, 4'd0, 8'h00, "rst_mid_tx");
    chk(1'b1, 4'd4, 8'h00, "rst_mid_reg4");
    reset = 1'b0;
    tick();
    rx(8'h05);
    rx(8'hAA);
    chk(1'b1, 4'd5, 8'h00, "post_rst_reg5");
    stop();
    hwr(4'd0, 8'hC3);
    hwr(4'd2, 8'h2E);
    start(1'b1);
    chk(1'b0, 4'd0, 8'hC3, "post_rst_rd");
    stop();

    tick();
    tick();
    checks++;
    if (exp_q.size() != 0 || wr_q.size() != 0) begin
      errors++;
      $display("FAIL leftover got %0d/%0d want 0/0",
               exp_q.size(), wr_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
